pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives enable and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and taken-branch/jump redirects.
- Sequences variable-latency data-memory accesses with a req/ack handshake and a timeout.

Parameters:
- MAX_WAIT, 16, data-memory wait cycles before abort; legal range 1..255.
- CNT_W, 32, width of optional performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- if_id_rs  in  5  rs field of instruction in IF/ID.
- if_id_rt  in  5  rt field of instruction in IF/ID.
- id_ex_mem_read  in  1  instruction in ID/EX is a load.
- id_ex_rt  in  5  load destination register in ID/EX.
- redirect  in  1  taken branch or jump resolved in ID.
- ex_mem_mem_op  in  1  instruction in EX/MEM performs a load or store.
- dmem_ack  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory access request.
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear to NOP.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_bubble  out  1  ID/EX loads zero control (NOP).
- ex_mem_en  out  1  EX/MEM load enable.
- mem_wb_en  out  1  MEM/WB load enable.
- mem_wb_bubble  out  1  MEM/WB loads zero wb control.
- mem_timeout  out  1  sticky flag: an access was aborted.

Behaviour:
- FSM states: RUN, WAIT. Reset (rst=0) forces state=RUN, wait_cnt=0, mem_timeout=0 immediately, regardless of clk.
- During reset all enables are 1 and all bubbles/flushes/dmem_req are 0, so the pipeline registers clear under their own reset.
- dmem_req = ex_mem_mem_op in RUN; 1 in WAIT.
- mem_stall = dmem_req & ~dmem_ack & ~abort. abort = (state==WAIT) & (wait_cnt==MAX_WAIT-1) & ~dmem_ack.
- RUN:
  - mem_op=1 with ack=1 completes in 0 extra cycles and the state stays RUN.
  - mem_op=1 with ack=0 moves to WAIT, wait_cnt=0.
- WAIT:
  - ack=1: move to RUN, wait_cnt=0; the pipeline advances this same cycle.
  - abort: move to RUN and set mem_timeout=1; the instruction advances with a bubble.
  - Otherwise wait_cnt increments.
- load_use = id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt).
- Priority is mem_stall > load_use > redirect. All outputs are combinational from state, wait_cnt and inputs; no added latency.
- When mem_stall=1:
  - pc_en=if_id_en=id_ex_en=ex_mem_en=0.
  - mem_wb_en=1 with mem_wb_bubble=1.
  - load_use and redirect are ignored; they are re-evaluated once the stall clears because the stage contents are held.
- When load_use=1 (no mem_stall):
  - pc_en=if_id_en=0.
  - id_ex_bubble=1; EX/MEM and MEM/WB advance.
  - Exactly one bubble is inserted.
  - redirect is suppressed this cycle and honoured next cycle.
- When redirect=1 (no mem_stall, no load_use): all enables are 1 and if_id_flush=1.
- On abort, mem_wb_bubble=1 for that cycle and all other enables are 1.
- mem_timeout is cleared only by reset.
- Reset asserted mid-WAIT returns the FSM to RUN and drops dmem_req combinationally (ex_mem_mem_op is cleared by the EX/MEM reset).

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, adds outputs stall_cycles and flush_count, each [CNT_W-1:0]:
  - stall_cycles increments on every cycle with mem_stall or load_use.
  - flush_count increments on every applied redirect.
  - Both wrap at 2^CNT_W, reset to 0 and are read-only.
- When undefined, the ports and counters do not exist.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state typedef (RUN, WAIT);
  - the REG_ZERO constant (5'd0);
  - the default MAX_WAIT.
- Sub-module hazard_detect is purely combinational and produces load_use from the rs/rt/mem_read compares; it is reused by the forwarding logic later.
- FSM and output mux stay in the top module.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle all enables are 1.
- Load into $0: id_ex_rt=0, if_id_rt=0, id_ex_mem_read=1 -> no stall.
- Zero-wait memory: ex_mem_mem_op=1, dmem_ack=1 same cycle -> dmem_req=1, no stall, state stays RUN.
- Three-cycle memory: mem_op=1 with ack on the 4th cycle:
  - 3 cycles show pc_en=0, ex_mem_en=0, mem_wb_bubble=1;
  - on the ack cycle mem_wb_bubble=0 and the state returns to RUN.
- Timeout, MAX_WAIT=4, ack never arrives:
  - abort occurs on the 5th request cycle and mem_timeout=1;
  - mem_timeout stays 1 until rst=0.
- Simultaneous events:
  - load_use plus redirect -> cycle 1 bubble only, cycle 2 if_id_flush=1.
  - mem_stall plus redirect -> flush is deferred until the stall clears.
  - rst=0 pulsed mid-WAIT -> RUN and dmem_req=0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam int unsigned DEFAULT_MAX_WAIT = 16;
  // Wide enough for any legal MAX_WAIT (1..255).
  localparam int unsigned WAIT_CNT_W       = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID/EX load destination and the IF/ID sources.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       i_id_ex_mem_read,
  input  logic [4:0] i_id_ex_rt,
  input  logic [4:0] i_if_id_rs,
  input  logic [4:0] i_if_id_rt,
  output logic       o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  always_comb begin
    w_rs_match = (i_id_ex_rt == i_if_id_rs);
    w_rt_match = (i_id_ex_rt == i_if_id_rt);
    // A load into $0 never produces a value, so it can never be a hazard.
    o_load_use = i_id_ex_mem_read && (i_id_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Optional performance counters are compiled in with PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             redirect,
  input  logic             ex_mem_mem_op,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_bubble,
  output logic             mem_timeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  if (MAX_WAIT == 0 || MAX_WAIT > 255 || CNT_W == 0) begin : g_bad_params
    $error("pipe_hazard_ctrl: MAX_WAIT must be 1..255 and CNT_W nonzero");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
  logic                  r_timeout;
  logic                  w_timeout_nxt;
  logic                  w_req;
  logic                  w_abort;
  logic                  w_mem_stall;
  logic                  w_load_use;

  hazard_detect u_hazard_detect (
    .i_id_ex_mem_read (id_ex_mem_read),
    .i_id_ex_rt       (id_ex_rt),
    .i_if_id_rs       (if_id_rs),
    .i_if_id_rt       (if_id_rt),
    .o_load_use       (w_load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_req       = (r_state == WAIT) ? 1'b1 : ex_mem_mem_op;
    w_abort     = (r_state == WAIT) && (r_wait_cnt == WAIT_LAST) && !dmem_ack;
    w_mem_stall = w_req && !dmem_ack && !w_abort;

    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_timeout;
    case (r_state)
      RUN: begin
        if (ex_mem_mem_op && !dmem_ack) begin
          w_state_nxt    = WAIT;
          w_wait_cnt_nxt = '0;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else if (w_abort) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
          w_timeout_nxt  = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase

    dmem_req      = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    mem_timeout   = r_timeout;

    // While reset is held every register clears itself, so all controls stay neutral.
    if (rst) begin
      dmem_req = w_req;
      if (w_mem_stall) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else begin
        if (w_abort) begin
          mem_wb_bubble = 1'b1;
        end
        if (w_load_use) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (redirect) begin
          if_id_flush = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_redirect_applied;

  assign w_redirect_applied = redirect && !w_mem_stall && !w_load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_mem_stall || w_load_use) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_redirect_applied) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (built with MAX_WAIT=4).
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rt;
  logic       redirect;
  logic       ex_mem_mem_op;
  logic       dmem_ack;
  logic       dmem_req;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_en;
  logic       id_ex_bubble;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       mem_wb_bubble;
  logic       mem_timeout;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .redirect       (redirect),
    .ex_mem_mem_op  (ex_mem_mem_op),
    .dmem_ack       (dmem_ack),
    .dmem_req       (dmem_req),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_en       (id_ex_en),
    .id_ex_bubble   (id_ex_bubble),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .mem_wb_bubble  (mem_wb_bubble),
    .mem_timeout    (mem_timeout)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mr;
    logic [4:0] xrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       redir;
    logic       memop;
    logic       ack;
  } stim_t;

  typedef struct {
    string      name;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [9:0] obs;
  assign obs = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                ex_mem_en, mem_wb_en, mem_wb_bubble, mem_timeout};

  function automatic stim_t S(logic mr, logic [4:0] xrt, logic [4:0] rs, logic [4:0] rt,
                              logic redir, logic memop, logic ack);
    return '{mr, xrt, rs, rt, redir, memop, ack};
  endfunction

  // Expected control vector: req, pc_en, if_id_en, flush, id_ex_en, bubble,
  // ex_mem_en, mem_wb_en, mem_wb_bubble, timeout.
  function automatic logic [9:0] E(logic req, logic pc, logic ifid, logic fl, logic idex,
                                   logic bub, logic exm, logic mwb, logic mwbub, logic to);
    return {req, pc, ifid, fl, idex, bub, exm, mwb, mwbub, to};
  endfunction

  task automatic drive(input stim_t s);
    id_ex_mem_read = s.mr;
    id_ex_rt       = s.xrt;
    if_id_rs       = s.rs;
    if_id_rt       = s.rt;
    redirect       = s.redir;
    ex_mem_mem_op  = s.memop;
    dmem_ack       = s.ack;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    drive(S(1, 5, 5, 5, 1, 1, 0));
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{"reset", E(0,1,1,0,1,0,1,1,0,0)});
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs, e.v);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(S(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    stim_t st[4];
    logic [9:0] ex[4];
    exp_t e;
    st[0] = S(1, 5, 5, 0, 0, 0, 0); ex[0] = E(0,0,0,0,1,1,1,1,0,0);
    st[1] = S(0, 0, 5, 0, 0, 0, 0); ex[1] = E(0,1,1,0,1,0,1,1,0,0);
    st[2] = S(1, 7, 3, 7, 0, 0, 0); ex[2] = E(0,0,0,0,1,1,1,1,0,0);
    st[3] = S(1, 7, 3, 6, 0, 0, 0); ex[3] = E(0,1,1,0,1,0,1,1,0,0);
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      sb.push_back('{"load_use", ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_zero();
    stim_t st[2];
    logic [9:0] ex[2];
    exp_t e;
    st[0] = S(1, 0, 0, 0, 0, 0, 0); ex[0] = E(0,1,1,0,1,0,1,1,0,0);
    st[1] = S(0, 5, 5, 5, 0, 0, 0); ex[1] = E(0,1,1,0,1,0,1,1,0,0);
    for (int i = 0; i < 2; i++) begin
      drive(st[i]);
      sb.push_back('{"load_zero", ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_wait();
    stim_t st[2];
    logic [9:0] ex[2];
    exp_t e;
    st[0] = S(0, 0, 0, 0, 0, 1, 1); ex[0] = E(1,1,1,0,1,0,1,1,0,0);
    st[1] = S(0, 0, 0, 0, 0, 0, 0); ex[1] = E(0,1,1,0,1,0,1,1,0,0);
    for (int i = 0; i < 2; i++) begin
      drive(st[i]);
      sb.push_back('{"zero_wait", ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_three_cycle();
    stim_t st[5];
    logic [9:0] ex[5];
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      st[i] = S(0, 0, 0, 0, 0, 1, 0); ex[i] = E(1,0,0,0,0,0,0,1,1,0);
    end
    st[3] = S(0, 0, 0, 0, 0, 1, 1); ex[3] = E(1,1,1,0,1,0,1,1,0,0);
    st[4] = S(0, 0, 0, 0, 0, 0, 0); ex[4] = E(0,1,1,0,1,0,1,1,0,0);
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      sb.push_back('{"three_cycle", ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[10];
    logic [9:0] ex[10];
    exp_t e;
    // load_use + redirect: bubble first, flush next cycle
    st[0] = S(1, 5, 5, 0, 1, 0, 0); ex[0] = E(0,0,0,0,1,1,1,1,0,0);
    st[1] = S(0, 0, 5, 0, 1, 0, 0); ex[1] = E(0,1,1,1,1,0,1,1,0,0);
    st[2] = S(0, 0, 0, 0, 0, 0, 0); ex[2] = E(0,1,1,0,1,0,1,1,0,0);
    // mem_stall + redirect: flush deferred to the ack cycle
    st[3] = S(0, 0, 0, 0, 1, 1, 0); ex[3] = E(1,0,0,0,0,0,0,1,1,0);
    st[4] = S(0, 0, 0, 0, 1, 1, 0); ex[4] = E(1,0,0,0,0,0,0,1,1,0);
    st[5] = S(0, 0, 0, 0, 1, 1, 1); ex[5] = E(1,1,1,1,1,0,1,1,0,0);
    st[6] = S(0, 0, 0, 0, 0, 0, 0); ex[6] = E(0,1,1,0,1,0,1,1,0,0);
    // mem_stall + load_use: load_use surfaces once the stall clears
    st[7] = S(1, 5, 5, 0, 0, 1, 0); ex[7] = E(1,0,0,0,0,0,0,1,1,0);
    st[8] = S(1, 5, 5, 0, 0, 1, 1); ex[8] = E(1,0,0,0,1,1,1,1,0,0);
    st[9] = S(0, 0, 5, 0, 0, 0, 0); ex[9] = E(0,1,1,0,1,0,1,1,0,0);
    for (int i = 0; i < 10; i++) begin
      drive(st[i]);
      sb.push_back('{"back_to_back", ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t st[8];
    logic [9:0] ex[8];
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      st[i] = S(0, 0, 0, 0, 0, 1, 0); ex[i] = E(1,0,0,0,0,0,0,1,1,0);
    end
    st[4] = S(0, 0, 0, 0, 0, 1, 0); ex[4] = E(1,1,1,0,1,0,1,1,1,0);
    st[5] = S(0, 0, 0, 0, 0, 0, 0); ex[5] = E(0,1,1,0,1,0,1,1,0,1);
    st[6] = S(0, 0, 0, 0, 0, 1, 1); ex[6] = E(1,1,1,0,1,0,1,1,0,1);
    st[7] = S(1, 9, 9, 0, 0, 0, 0); ex[7] = E(0,0,0,0,1,1,1,1,0,1);
    for (int i = 0; i < 8; i++) begin
      drive(st[i]);
      sb.push_back('{"timeout", ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    drive(S(0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{"mid_wait_stall", E(1,0,0,0,0,0,0,1,1,1)});
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs, e.v);
      end
      if (i == 0) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b0;
    sb.push_back('{"mid_wait_reset", E(0,1,1,0,1,0,1,1,0,0)});
    #1;
    e = sb.pop_front();
    tests++;
    if (obs !== e.v) begin
      fails++;
      $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(S(0, 0, 0, 0, 0, 0, 0));
    sb.push_back('{"after_reset_run", E(0,1,1,0,1,0,1,1,0,0)});
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (obs !== e.v) begin
      fails++;
      $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_load_zero();
    test_zero_wait();
    test_three_cycle();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
